branch_ex: RTL and testbench



---
 rtl/branch_ex_pkg.sv | 23 ++
 rtl/branch_ex_chk.sv | 16 +
 rtl/branch_ex_resolve.sv | 53 +++++
 rtl/branch_ex.sv | 179 +++++++++++++++++
 tb/tb_branch_ex.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_ex_pkg.sv
// Shared types and constants for the branch execution stage.
// The optional statistics counters are enabled with the BRANCH_STAT_EN macro.
package branch_ex_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [5:0] OP_BEQ  = 6'd1;
    localparam logic [5:0] OP_BNE  = 6'd2;
    localparam logic [5:0] OP_BLT  = 6'd3;
    localparam logic [5:0] OP_BGE  = 6'd4;
    localparam logic [5:0] OP_BLTU = 6'd5;
    localparam logic [5:0] OP_BGEU = 6'd6;
    localparam logic [5:0] OP_JAL  = 6'd7;
    localparam logic [5:0] OP_JALR = 6'd8;

    // Tag value shown on resTag when no instruction has ever been held.
    localparam int unsigned TAG_FREE = 0;

endpackage

// File: rtl/branch_ex_chk.sv
// Protocol checker for branch_ex: the reservation station must not issue
// into a full stage (an issue coinciding with clear is harmlessly dropped).
module branch_ex_chk (
    input logic clk,
    input logic rst,
    input logic rdy,
    input logic clear,
    input logic issue_i,
    input logic busy_i
);

    a_no_issue_when_busy: assert property (
        @(posedge clk) disable iff (rst) !(rdy && !clear && issue_i && busy_i)
    ) else $error("branch_ex: issue while busy, instruction ignored");

endmodule

// File: rtl/branch_ex_resolve.sv
// branch_resolve: combinational condition/target/link/mispredict evaluation
// for a single branch or jump.
module branch_resolve
    import branch_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic [DATA_W-1:0] link_o,
    output logic              mispredict_o
);

    logic              taken_s;
    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] target_s;

    // Condition, target and link selection per opcode
    always_comb begin
        pc_plus4_s = pc_i + ADDR_W'(4);
        target_s   = pc_i + ADDR_W'(imm_i);
        taken_s    = 1'b0;
        link_o     = '0;
        case (op_i)
            OP_BEQ:  taken_s = (opa_i == opb_i);
            OP_BNE:  taken_s = (opa_i != opb_i);
            OP_BLT:  taken_s = ($signed(opa_i) <  $signed(opb_i));
            OP_BGE:  taken_s = ($signed(opa_i) >= $signed(opb_i));
            OP_BLTU: taken_s = (opa_i <  opb_i);
            OP_BGEU: taken_s = (opa_i >= opb_i);
            OP_JAL: begin
                taken_s = 1'b1;
                link_o  = DATA_W'(pc_plus4_s);
            end
            OP_JALR: begin
                taken_s  = 1'b1;
                link_o   = DATA_W'(pc_plus4_s);
                target_s = ADDR_W'(opa_i + imm_i) & ~ADDR_W'(1);
            end
            default: taken_s = 1'b0;
        endcase
        next_pc_o    = taken_s ? target_s : pc_plus4_s;
        mispredict_o = (next_pc_o != pred_pc_i);
    end

endmodule

// File: rtl/branch_ex.sv
// branch_ex: branch execution stage with output register and one-entry skid
// buffer toward the CDB. Define BRANCH_STAT_EN to add saturating stat counters.
module branch_ex
    import branch_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              BranchWorkEn,
    input  logic [DATA_W-1:0] operandO,
    input  logic [DATA_W-1:0] operandT,
    input  logic [DATA_W-1:0] imm,
    input  logic [OP_W-1:0]   opCode,
    input  logic [ADDR_W-1:0] PC,
    input  logic [TAG_W-1:0]  destTag,
    input  logic [ADDR_W-1:0] predPC,
    output logic              busy,
    output logic              resValid,
    output logic [TAG_W-1:0]  resTag,
    output logic [DATA_W-1:0] resData,
    output logic              resMispredict,
    output logic [ADDR_W-1:0] resNextPC,
    input  logic              cdbGrant
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0]       statBranches,
    output logic [31:0]       statMispredicts
`endif
);

    state_e            state_q, state_d;
    logic              out_load_new_s, out_load_skd_s, skd_load_s;
    logic [ADDR_W-1:0] new_npc_s;
    logic [DATA_W-1:0] new_link_s;
    logic              new_mis_s;

    logic [TAG_W-1:0]  out_tag_q, skd_tag_q;
    logic [DATA_W-1:0] out_data_q, skd_data_q;
    logic              out_mis_q, skd_mis_q;
    logic [ADDR_W-1:0] out_npc_q, skd_npc_q;

    branch_resolve #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) u_resolve (
        .op_i        (opCode),
        .opa_i       (operandO),
        .opb_i       (operandT),
        .imm_i       (imm),
        .pc_i        (PC),
        .pred_pc_i   (predPC),
        .next_pc_o   (new_npc_s),
        .link_o      (new_link_s),
        .mispredict_o(new_mis_s)
    );

    branch_ex_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .clear  (clear),
        .issue_i(BranchWorkEn),
        .busy_i (busy)
    );

    // Next-state and register load selection for the OUT/SKD pair
    always_comb begin
        state_d        = state_q;
        out_load_new_s = 1'b0;
        out_load_skd_s = 1'b0;
        skd_load_s     = 1'b0;
        if (clear) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (BranchWorkEn) begin
                        state_d        = ST_ONE;
                        out_load_new_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (cdbGrant && BranchWorkEn) begin
                        out_load_new_s = 1'b1;
                    end else if (cdbGrant) begin
                        state_d = ST_EMPTY;
                    end else if (BranchWorkEn) begin
                        state_d    = ST_TWO;
                        skd_load_s = 1'b1;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // Issues here are protocol errors and are ignored.
                    if (cdbGrant) begin
                        state_d        = ST_ONE;
                        out_load_skd_s = 1'b1;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and result registers; rdy low freezes everything except reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_tag_q  <= TAG_W'(TAG_FREE);
            out_data_q <= '0;
            out_mis_q  <= 1'b0;
            out_npc_q  <= '0;
            skd_tag_q  <= TAG_W'(TAG_FREE);
            skd_data_q <= '0;
            skd_mis_q  <= 1'b0;
            skd_npc_q  <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            if (out_load_new_s) begin
                out_tag_q  <= destTag;
                out_data_q <= new_link_s;
                out_mis_q  <= new_mis_s;
                out_npc_q  <= new_npc_s;
            end else if (out_load_skd_s) begin
                out_tag_q  <= skd_tag_q;
                out_data_q <= skd_data_q;
                out_mis_q  <= skd_mis_q;
                out_npc_q  <= skd_npc_q;
            end
            if (skd_load_s) begin
                skd_tag_q  <= destTag;
                skd_data_q <= new_link_s;
                skd_mis_q  <= new_mis_s;
                skd_npc_q  <= new_npc_s;
            end
        end
    end

    assign resValid      = (state_q != ST_EMPTY);
    assign busy          = (state_q == ST_TWO);
    assign resTag        = out_tag_q;
    assign resData       = out_data_q;
    assign resMispredict = out_mis_q;
    assign resNextPC     = out_npc_q;

`ifdef BRANCH_STAT_EN
    logic        granted_s;
    logic [31:0] stat_br_q, stat_mis_q;

    assign granted_s = rdy && !clear && cdbGrant && resValid;

    // Saturating counters of granted results; immune to clear
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q  <= 32'd0;
            stat_mis_q <= 32'd0;
        end else if (granted_s) begin
            if (stat_br_q != 32'hFFFF_FFFF) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (out_mis_q && (stat_mis_q != 32'hFFFF_FFFF)) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign statBranches    = stat_br_q;
    assign statMispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_ex.sv
// Self-checking bench for branch_ex: directed scenarios followed by random
// traffic, compared against a queue-based reference of the stage.
module tb_branch_ex;
    import branch_ex_pkg::*;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic        mis;
        logic [31:0] npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, BranchWorkEn, cdbGrant;
    logic [31:0] operandO, operandT, imm, PC, predPC;
    logic [5:0]  opCode;
    logic [3:0]  destTag;
    logic        busy, resValid, resMispredict;
    logic [3:0]  resTag;
    logic [31:0] resData, resNextPC;
`ifdef BRANCH_STAT_EN
    logic [31:0] statBranches, statMispredicts;
    int unsigned m_br, m_mis;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    branch_ex dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .BranchWorkEn(BranchWorkEn), .operandO(operandO), .operandT(operandT),
        .imm(imm), .opCode(opCode), .PC(PC), .destTag(destTag), .predPC(predPC),
        .busy(busy), .resValid(resValid), .resTag(resTag), .resData(resData),
        .resMispredict(resMispredict), .resNextPC(resNextPC), .cdbGrant(cdbGrant)
`ifdef BRANCH_STAT_EN
        , .statBranches(statBranches), .statMispredicts(statMispredicts)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Architectural meaning of one branch, written straight from the ISA rules.
    function automatic exp_t ref_res(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] im,
                                     input logic [31:0] pc, input logic [31:0] pred);
        exp_t e;
        bit   t;
        logic [31:0] seq, tgt;
        seq = pc + 32'd4;
        tgt = pc + im;
        case (op)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = (int'(a) < int'(b));
            OP_BGE:  t = !(int'(a) < int'(b));
            OP_BLTU: t = (a < b);
            OP_BGEU: t = !(a < b);
            OP_JAL:  t = 1'b1;
            OP_JALR: begin t = 1'b1; tgt = (a + im) & 32'hFFFF_FFFE; end
            default: t = 1'b0;
        endcase
        e.tag  = 4'd0;
        e.npc  = t ? tgt : seq;
        e.data = (op == OP_JAL || op == OP_JALR) ? seq : 32'd0;
        e.mis  = (e.npc != pred);
        return e;
    endfunction

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc,
                         input logic [3:0] tg, input logic [31:0] pred);
        BranchWorkEn = 1'b1; opCode = op; operandO = a; operandT = b;
        imm = im; PC = pc; destTag = tg; predPC = pred;
    endtask

    task automatic check_outputs();
        chk("resValid", 64'(resValid), 64'(q.size() != 0));
        chk("busy", 64'(busy), 64'(q.size() == 2));
        if (q.size() != 0) begin
            chk("resTag", 64'(resTag), 64'(q[0].tag));
            chk("resData", 64'(resData), 64'(q[0].data));
            chk("resMispredict", 64'(resMispredict), 64'(q[0].mis));
            chk("resNextPC", 64'(resNextPC), 64'(q[0].npc));
        end
`ifdef BRANCH_STAT_EN
        chk("statBranches", 64'(statBranches), 64'(m_br));
        chk("statMispredicts", 64'(statMispredicts), 64'(m_mis));
`endif
    endtask

    // One clock: advance the reference with the inputs seen at the edge, then compare.
    task automatic cyc();
        exp_t e;
        bit   accept;
        @(posedge clk);
        if (rst) begin
            q.delete();
`ifdef BRANCH_STAT_EN
            m_br = 0; m_mis = 0;
`endif
        end else if (rdy) begin
            if (clear) begin
                q.delete();
            end else begin
                accept = BranchWorkEn && (q.size() < 2);
                if (cdbGrant && q.size() != 0) begin
`ifdef BRANCH_STAT_EN
                    if (m_br != 32'hFFFF_FFFF) m_br++;
                    if (q[0].mis && m_mis != 32'hFFFF_FFFF) m_mis++;
`endif
                    void'(q.pop_front());
                end
                if (accept) begin
                    e = ref_res(opCode, operandO, operandT, imm, PC, predPC);
                    e.tag = destTag;
                    q.push_back(e);
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 64'(resValid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_tag"}, 64'(resTag), 64'(TAG_FREE));
        chk({tag, "_data"}, 64'(resData), 64'd0);
        chk({tag, "_mis"}, 64'(resMispredict), 64'd0);
        chk({tag, "_npc"}, 64'(resNextPC), 64'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; BranchWorkEn = 1'b0; cdbGrant = 1'b0;
        operandO = 32'd0; operandT = 32'd0; imm = 32'd0; PC = 32'd0;
        predPC = 32'd0; opCode = 6'd0; destTag = 4'd0;
`ifdef BRANCH_STAT_EN
        m_br = 0; m_mis = 0;
`endif
        cyc(); cyc();
        rst = 1'b0;
        check_reset_values("reset");

        // BEQ taken, prediction wrong
        cdbGrant = 1'b1;
        issue(OP_BEQ, 32'd5, 32'd5, 32'h20, 32'h100, 4'd1, 32'h104);
        cyc();
        chk("t1_npc", 64'(resNextPC), 64'h120);
        chk("t1_mis", 64'(resMispredict), 64'd1);
        chk("t1_data", 64'(resData), 64'd0);

        // Signed vs unsigned compare of the same operands
        issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 4'd2, 32'h240);
        cyc();
        chk("t2_blt_npc", 64'(resNextPC), 64'h240);
        issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 4'd3, 32'h240);
        cyc();
        chk("t2_bltu_npc", 64'(resNextPC), 64'h204);

        // JALR clears bit 0 of the target, link is PC+4
        issue(OP_JALR, 32'h203, 32'd0, 32'd0, 32'h40, 4'd4, 32'h202);
        cyc();
        chk("t3_npc", 64'(resNextPC), 64'h202);
        chk("t3_data", 64'(resData), 64'h44);
        chk("t3_mis", 64'(resMispredict), 64'd0);
        BranchWorkEn = 1'b0;
        cyc();

        // Fill both entries, then drain in order
        cdbGrant = 1'b0;
        issue(OP_BNE, 32'd1, 32'd2, 32'h10, 32'h300, 4'd5, 32'h310);
        cyc();
        issue(OP_JAL, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h400, 4'd6, 32'h404);
        cyc();
        chk("t4_busy", 64'(busy), 64'd1);
        BranchWorkEn = 1'b0;
        cyc();
        cdbGrant = 1'b1;
        cyc();
        chk("t4_second_tag", 64'(resTag), 64'd6);
        cyc();
        chk("t4_drained_valid", 64'(resValid), 64'd0);
        chk("t4_drained_busy", 64'(busy), 64'd0);

        // clear in TWO with a simultaneous issue
        cdbGrant = 1'b0;
        issue(OP_BGE, 32'd3, 32'd3, 32'h8, 32'h500, 4'd7, 32'h508);
        cyc();
        issue(OP_BGEU, 32'd1, 32'd3, 32'h8, 32'h600, 4'd8, 32'h604);
        cyc();
        clear = 1'b1;
        issue(OP_BEQ, 32'd9, 32'd9, 32'h8, 32'h700, 4'd9, 32'h704);
        cyc();
        clear = 1'b0; BranchWorkEn = 1'b0;
        chk("t5_valid", 64'(resValid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        cdbGrant = 1'b1;
        cyc(); cyc();

        // Reset while holding a result
        cdbGrant = 1'b0;
        issue(OP_JAL, 32'd0, 32'd0, 32'h100, 32'h800, 4'd10, 32'h900);
        cyc();
        BranchWorkEn = 1'b0;
        rst = 1'b1;
        cyc();
        check_reset_values("midreset");
`ifdef BRANCH_STAT_EN
        chk("midreset_statBr", 64'(statBranches), 64'd0);
        chk("midreset_statMis", 64'(statMispredicts), 64'd0);
`endif
        rst = 1'b0;

        // Random traffic including rdy stalls and flushes
        for (int i = 0; i < 600; i++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            cdbGrant = $urandom_range(0, 1);
            opCode   = 6'($urandom_range(0, 9));
            operandO = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 31))
                                                     : $urandom);
            operandT = ($urandom_range(0, 2) == 0) ? operandO : $urandom;
            imm      = $urandom;
            PC       = $urandom;
            destTag  = 4'($urandom_range(0, 15));
            predPC   = ($urandom_range(0, 1) == 0) ? PC + 32'd4 : $urandom;
            BranchWorkEn = ($urandom_range(0, 2) != 0) && ((q.size() < 2) || clear);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
